sensor_frame_uart_tx: RTL and testbench

SENSOR_FRAME_UART_TX -- requirements
Module: sensor_frame_uart_tx

---
 rtl/sensor_frame_uart_tx_pkg.sv | 23 ++
 rtl/sensor_frame_uart_tx_uart_byte_tx.sv | 55 +++++
 rtl/sensor_frame_uart_tx.sv | 100 ++++++++++
 tb/tb_sensor_frame_uart_tx.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_frame_uart_tx_pkg.sv
// Shared frame constants and types for the sensor frame UART transmitter.
// A frame is the header byte, PAYLOAD_BYTES of zero-padded sensor word
// (least significant byte first), then the XOR checksum of the payload.
package sensor_frame_uart_tx_pkg;

    localparam logic [7:0] DEF_HEADER_BYTE = 8'hA5;
    localparam int         FRAME_BYTES     = 15;
    localparam int         PAYLOAD_BYTES   = 13;
    localparam int         PAD_W           = 8 * PAYLOAD_BYTES;  // 104
    localparam int         SENSOR_W        = 102;

    // Frame-level phases: START = header byte on the line, DATA = payload
    // bytes, STOP = checksum byte, DONE = one-cycle handshake back to parser.
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} frame_state_e;

    function automatic logic [7:0] payload_xor(input logic [PAD_W-1:0] p);
        logic [7:0] x;
        x = '0;
        for (int k = 0; k < PAYLOAD_BYTES; k++) x ^= p[8*k +: 8];
        return x;
    endfunction

endpackage

// File: rtl/sensor_frame_uart_tx_uart_byte_tx.sv
// Single-byte 8N1 serializer.
//   clk_72MHz, rst_n : clock, async active-low reset
//   start, data      : load data and begin the start bit on the next cycle
//   tx               : UART line (flop output, idle high)
//   done             : high during the last cycle of the stop bit; a start
//                      in that same cycle chains the next byte with no gap
module uart_byte_tx #(
    parameter int CLKS_PER_BIT = 72
) (
    input  logic       clk_72MHz,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

    logic [9:0]    shifter;   // {stop, data[7:0], start}; bit 0 is on the line
    logic [CW-1:0] bit_cnt;
    logic [3:0]    bit_idx;
    logic          active;

    assign tx   = shifter[0];
    assign done = active && (bit_cnt == '0) && (bit_idx == 4'd9);

    always_ff @(posedge clk_72MHz or negedge rst_n) begin
        if (!rst_n) begin
            shifter <= '1;
            bit_cnt <= '0;
            bit_idx <= '0;
            active  <= 1'b0;
        end else if (start) begin
            shifter <= {1'b1, data, 1'b0};
            bit_cnt <= RELOAD;
            bit_idx <= '0;
            active  <= 1'b1;
        end else if (active) begin
            if (bit_cnt == '0) begin
                bit_cnt <= RELOAD;
                // On the final bit the stop level simply stays on the line.
                if (bit_idx == 4'd9) begin
                    active <= 1'b0;
                end else begin
                    bit_idx <= bit_idx + 4'd1;
                    shifter <= {1'b1, shifter[9:1]};
                end
            end else begin
                bit_cnt <= bit_cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/sensor_frame_uart_tx.sv
// Sends one 15-byte frame per captured sensor word over an 8N1 UART.
//   clk_72MHz, rst_n  : clock, async active-low reset
//   sensor_iterations : 102-bit sensor word, valid with data_avl
//   data_avl          : capture strobe (only honoured in IDLE)
//   reset_parser      : one-cycle pulse after the checksum stop bit
//   tx                : UART line, idle high
//   busy              : frame in progress (capture through DONE)
//   dropped_cnt       : saturating count of strobes ignored while busy
module sensor_frame_uart_tx
    import sensor_frame_uart_tx_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 72,
    parameter logic [7:0] HEADER_BYTE  = DEF_HEADER_BYTE
) (
    input  logic                clk_72MHz,
    input  logic                rst_n,
    input  logic [SENSOR_W-1:0] sensor_iterations,
    input  logic                data_avl,
    output logic                reset_parser,
    output logic                tx,
    output logic                busy,
    output logic [7:0]          dropped_cnt
);
    // Index of the last payload byte; once it completes, the checksum follows.
    localparam logic [3:0] LAST_PAYLOAD_IDX = 4'(FRAME_BYTES - 2);

    frame_state_e     state, state_nxt;
    logic [PAD_W-1:0] shadow;
    logic [3:0]       byte_idx;
    logic [7:0]       checksum, next_byte, bt_data;
    logic             capture, bt_start, bt_done;

    assign checksum = payload_xor(shadow);
    assign capture  = (state == IDLE) && data_avl;
    assign busy         = (state != IDLE);
    assign reset_parser = (state == DONE);

    // Byte following byte_idx: payload byte k lives at frame index k+1,
    // so the byte after index k is payload k, or the checksum after index 13.
    always_comb begin
        next_byte = checksum;
        if (byte_idx < LAST_PAYLOAD_IDX) next_byte = shadow[8*int'(byte_idx) +: 8];
    end

    always_comb begin
        state_nxt = state;
        bt_start  = 1'b0;
        bt_data   = next_byte;
        case (state)
            IDLE: if (data_avl) begin
                state_nxt = START;
                bt_start  = 1'b1;
                bt_data   = HEADER_BYTE;
            end
            START: if (bt_done) begin
                state_nxt = DATA;
                bt_start  = 1'b1;
            end
            DATA: if (bt_done) begin
                bt_start = 1'b1;
                if (byte_idx == LAST_PAYLOAD_IDX) state_nxt = STOP;
            end
            STOP: if (bt_done) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_72MHz or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk_72MHz or negedge rst_n) begin
        if (!rst_n) begin
            shadow   <= '0;
            byte_idx <= '0;
        end else if (capture) begin
            shadow   <= {2'b00, sensor_iterations};
            byte_idx <= '0;
        end else if (bt_start) begin
            byte_idx <= byte_idx + 4'd1;
        end
    end

    always_ff @(posedge clk_72MHz or negedge rst_n) begin
        if (!rst_n)                                          dropped_cnt <= '0;
        else if (data_avl && busy && dropped_cnt != 8'hFF)   dropped_cnt <= dropped_cnt + 8'd1;
    end

    uart_byte_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte_tx (
        .clk_72MHz (clk_72MHz),
        .rst_n     (rst_n),
        .start     (bt_start),
        .data      (bt_data),
        .tx        (tx),
        .done      (bt_done)
    );

endmodule

// File: tb/tb_sensor_frame_uart_tx.sv
// Bench for sensor_frame_uart_tx at CLKS_PER_BIT=4: a cycle-position model
// predicts tx/busy/reset_parser/dropped_cnt every cycle, a UART receiver
// decodes the line, and directed frames are pinned with literal byte lists.
module tb_sensor_frame_uart_tx;
    localparam int CPB       = 4;
    localparam int FRAME_CYC = 150 * CPB;

    logic         clk_72MHz = 1'b0;
    logic         rst_n     = 1'b0;
    logic         data_avl  = 1'b0;
    logic [101:0] sensor_iterations = '0;
    logic         reset_parser, tx, busy;
    logic [7:0]   dropped_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clk_72MHz = ~clk_72MHz;
    always @(posedge clk_72MHz) cyc <= cyc + 1;

    sensor_frame_uart_tx #(.CLKS_PER_BIT(CPB), .HEADER_BYTE(8'hA5)) dut (
        .clk_72MHz         (clk_72MHz),
        .rst_n             (rst_n),
        .sensor_iterations (sensor_iterations),
        .data_avl          (data_avl),
        .reset_parser      (reset_parser),
        .tx                (tx),
        .busy              (busy),
        .dropped_cnt       (dropped_cnt)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Frame as 15 bytes, byte k at [8k+:8].
    function automatic logic [119:0] build_frame(input logic [101:0] s);
        logic [103:0] p;
        logic [7:0]   cs;
        logic [119:0] f;
        p = {2'b00, s};
        cs = '0;
        f = '0;
        f[7:0] = 8'hA5;
        for (int k = 0; k < 13; k++) begin
            f[8*(k+1) +: 8] = p[8*k +: 8];
            cs ^= p[8*k +: 8];
        end
        f[119:112] = cs;
        return f;
    endfunction

    // Line level n cycles after the capture edge.
    function automatic logic exp_tx(input logic [119:0] f, input int n);
        int b, pos;
        logic [7:0] by;
        if (n < 1 || n > FRAME_CYC) return 1'b1;
        b   = (n - 1) / CPB;
        by  = f[8*(b/10) +: 8];
        pos = b % 10;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return by[pos-1];
    endfunction

    // Model: m_n = cycles since capture (0 = idle).
    int           m_n    = 0;
    int           m_drop = 0;
    logic [119:0] m_frame = '0;
    always @(posedge clk_72MHz or negedge rst_n) begin
        if (!rst_n) begin
            m_n <= 0; m_drop <= 0; m_frame <= '0;
        end else if (m_n == 0) begin
            if (data_avl) begin
                m_n <= 1;
                m_frame <= build_frame(sensor_iterations);
            end
        end else begin
            if (data_avl && m_drop < 255) m_drop <= m_drop + 1;
            m_n <= (m_n == FRAME_CYC + 1) ? 0 : m_n + 1;
        end
    end

    always @(negedge clk_72MHz) begin
        chk("model_tx",   128'(tx),           128'(exp_tx(m_frame, m_n)));
        chk("model_busy", 128'(busy),         128'(m_n != 0));
        chk("model_rp",   128'(reset_parser), 128'(m_n == FRAME_CYC + 1));
        chk("model_drop", 128'(dropped_cnt),  128'(m_drop));
    end

    // UART receiver: rx_cnt = cycle within byte, sample mid-bit.
    logic [7:0] rx_q[$];
    logic [7:0] rx_sh = '0;
    int         rx_cnt = -1;
    always @(negedge clk_72MHz or negedge rst_n) begin
        if (!rst_n) rx_cnt <= -1;
        else if (rx_cnt < 0) begin
            if (tx == 1'b0) rx_cnt <= 2;
        end else begin
            if (rx_cnt >= 7 && rx_cnt <= 35 && (rx_cnt % 4) == 3) rx_sh[(rx_cnt-7)/4] <= tx;
            if (rx_cnt == 39) begin
                rx_q.push_back(rx_sh);
                rx_cnt <= -1;
            end else rx_cnt <= rx_cnt + 1;
        end
    end

    task automatic strobe(input logic [101:0] s, output int c0);
        @(negedge clk_72MHz); #1;
        sensor_iterations = s;
        data_avl = 1'b1;
        c0 = cyc;
        @(negedge clk_72MHz); #1;
        data_avl = 1'b0;
        chk("tx_low_latency1", 128'(tx), 128'(1'b0));
        chk("busy_after_capture", 128'(busy), 128'(1'b1));
    endtask

    task automatic wait_done(input int c0);
        int rp_cnt, rp_at;
        logic busy_after;
        rp_cnt = 0; rp_at = -1; busy_after = 1'b1;
        for (int i = 0; i < FRAME_CYC + 20; i++) begin
            @(negedge clk_72MHz); #1;
            if (reset_parser) begin rp_cnt++; rp_at = cyc - c0; end
            if (rp_cnt > 0 && (cyc - c0) == rp_at + 1) busy_after = busy;
        end
        chk("rp_pulse_count", 128'(rp_cnt), 128'(1));
        chk("rp_latency", 128'(rp_at), 128'(FRAME_CYC + 1));
        chk("busy_low_after_rp", 128'(busy_after), 128'(1'b0));
    endtask

    task automatic chk_bytes(input logic [119:0] exp);
        chk("rx_byte_count", 128'(rx_q.size()), 128'(15));
        for (int k = 0; k < 15; k++)
            chk($sformatf("rx_byte%0d", k), (k < rx_q.size()) ? 128'(rx_q[k]) : 128'hDEAD, 128'(exp[8*k +: 8]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1, drop_before;
        bit seen;
        repeat (3) @(negedge clk_72MHz);
        #1;
        chk("reset_tx",   128'(tx),           128'(1'b1));
        chk("reset_busy", 128'(busy),         128'(1'b0));
        chk("reset_rp",   128'(reset_parser), 128'(1'b0));
        chk("reset_drop", 128'(dropped_cnt),  128'(0));
        rst_n = 1'b1;
        @(negedge clk_72MHz);

        // Minimal word.
        rx_q.delete();
        strobe(102'h1, c0);
        wait_done(c0);
        chk_bytes({8'h01, {12{8'h00}}, 8'h01, 8'hA5});

        // All ones, input scrambled while busy.
        rx_q.delete();
        strobe({102{1'b1}}, c0);
        sensor_iterations = {6'($urandom), $urandom, $urandom, $urandom};
        wait_done(c0);
        chk_bytes({8'h3F, 8'h3F, {12{8'hFF}}, 8'hA5});

        // 300 strobes while busy saturate the drop counter.
        rx_q.delete();
        strobe(102'h12345, c0);
        data_avl = 1'b1;
        for (int i = 0; i < 300; i++) begin
            sensor_iterations = {6'($urandom), $urandom, $urandom, $urandom};
            @(negedge clk_72MHz); #1;
        end
        data_avl = 1'b0;
        wait_done(c0);
        chk("drop_saturated", 128'(dropped_cnt), 128'(255));
        chk_bytes({8'h67, {10{8'h00}}, 8'h01, 8'h23, 8'h45, 8'hA5});

        // Reset 200 cycles into a frame.
        strobe(102'h1, c0);
        while (cyc - c0 < 200) @(negedge clk_72MHz);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_tx",   128'(tx),           128'(1'b1));
        chk("abort_busy", 128'(busy),         128'(1'b0));
        chk("abort_rp",   128'(reset_parser), 128'(1'b0));
        chk("abort_drop", 128'(dropped_cnt),  128'(0));
        repeat (3) @(negedge clk_72MHz);
        #2 rst_n = 1'b1;
        repeat (5) @(negedge clk_72MHz);
        #1;
        chk("post_reset_idle_busy", 128'(busy), 128'(1'b0));
        rx_q.delete();
        strobe(102'h0, c0);
        wait_done(c0);
        chk_bytes({{14{8'h00}}, 8'hA5});

        // Strobe in DONE is dropped; strobe on the next cycle captures.
        strobe(102'h1, c0);
        seen = 1'b0;
        for (int i = 0; i < FRAME_CYC + 20 && !seen; i++) begin
            @(negedge clk_72MHz); #1;
            if (reset_parser) seen = 1'b1;
        end
        chk("done_seen", 128'(seen), 128'(1'b1));
        if (seen) begin
            drop_before = int'(dropped_cnt);
            rx_q.delete();
            sensor_iterations = 102'hFF00;
            data_avl = 1'b1;
            @(negedge clk_72MHz); #1;
            chk("drop_in_done", 128'(dropped_cnt), 128'(drop_before + 1));
            chk("idle_after_done", 128'(busy), 128'(1'b0));
            c1 = cyc;
            @(negedge clk_72MHz); #1;
            data_avl = 1'b0;
            chk("rearm_tx_low", 128'(tx), 128'(1'b0));
            wait_done(c1);
            chk_bytes({8'hFF, {11{8'h00}}, 8'hFF, 8'h00, 8'hA5});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
